// File: rtl/inst_fetch_v2.sv
// Instruction sequencer: holds each stored word on INST for HOLD_CYCLES clocks; first word one cycle after run, stall freezes.
// Optional sentinel halt on 32'hFFFF_FFFF is enabled by defining IFETCH_HALT_EN.
module inst_fetch_v2 #(
   parameter int DEPTH_LOG2  = 6,
   parameter int HOLD_CYCLES = 2
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  load_en,
   input  logic [DEPTH_LOG2-1:0] load_addr,
   input  logic [31:0]           load_data,
   input  logic                  run,
   input  logic                  stall,
   input  logic                  redirect_en,
   input  logic [DEPTH_LOG2-1:0] redirect_addr,
   output logic [31:0]           INST,
   output logic [DEPTH_LOG2-1:0] pc,
   output logic                  inst_valid,
   output logic                  issue,
   output logic                  halted
);

   localparam logic [3:0]  CNT_RELOAD = 4'(HOLD_CYCLES - 1);
   localparam logic [31:0] SENTINEL   = 32'hFFFF_FFFF;

   typedef enum logic [1:0] {IDLE, HOLD, HALT} state_t;

   state_t                state_q, state_n;
   logic [31:0]           inst_q, inst_n;
   logic [DEPTH_LOG2-1:0] pc_q, pc_n;
   logic [3:0]            cnt_q, cnt_n;
   logic                  issue_q, issue_n;

   logic [31:0]           mem [2**DEPTH_LOG2];
   logic [DEPTH_LOG2-1:0] fetch_addr;
   logic [31:0]           fetch_word;
   logic                  fetch_halt;

   // Program store survives reset; writable only while idle and not running.
   always_ff @(posedge CLK) begin
      if (state_q == IDLE && load_en && !run)
         mem[load_addr] <= load_data;
   end

   assign fetch_addr = (state_q == IDLE) ? '0
                     : (redirect_en ? redirect_addr : pc_q + 1'b1);
   assign fetch_word = mem[fetch_addr];
`ifdef IFETCH_HALT_EN
   assign fetch_halt = (fetch_word == SENTINEL);
`else
   assign fetch_halt = 1'b0;
`endif

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q <= IDLE;
         inst_q  <= '0;
         pc_q    <= '0;
         cnt_q   <= '0;
         issue_q <= 1'b0;
      end else begin
         state_q <= state_n;
         inst_q  <= inst_n;
         pc_q    <= pc_n;
         cnt_q   <= cnt_n;
         issue_q <= issue_n;
      end
   end

   always_comb begin
      state_n = state_q;
      inst_n  = inst_q;
      pc_n    = pc_q;
      cnt_n   = cnt_q;
      issue_n = 1'b0;
      if (!run) begin
         state_n = IDLE;
         inst_n  = '0;
         pc_n    = '0;
         cnt_n   = '0;
      end else begin
         case (state_q)
            IDLE, HOLD: begin
               // A fetch happens on start from IDLE or at an unstalled hold boundary.
               if (state_q == IDLE || (!stall && cnt_q == 4'd0)) begin
                  pc_n = fetch_addr;
                  if (fetch_halt) begin
                     state_n = HALT;
                     inst_n  = '0;
                     cnt_n   = '0;
                  end else begin
                     state_n = HOLD;
                     inst_n  = fetch_word;
                     cnt_n   = CNT_RELOAD;
                     issue_n = 1'b1;
                  end
               end else if (!stall) begin
                  cnt_n = cnt_q - 4'd1;
               end
            end
            default: ;
         endcase
      end
   end

   assign INST       = inst_q;
   assign pc         = pc_q;
   assign issue      = issue_q;
   assign inst_valid = (state_q == HOLD);
`ifdef IFETCH_HALT_EN
   assign halted     = (state_q == HALT);
`else
   assign halted     = 1'b0;
`endif

endmodule

// File: tb/tb_inst_fetch_v2.sv
// Directed bench for inst_fetch_v2 with default parameters (64 words, hold of 2).
module tb_inst_fetch_v2;

   logic        CLK = 1'b0;
   logic        RST;
   logic        load_en;
   logic [5:0]  load_addr;
   logic [31:0] load_data;
   logic        run;
   logic        stall;
   logic        redirect_en;
   logic [5:0]  redirect_addr;
   logic [31:0] INST;
   logic [5:0]  pc;
   logic        inst_valid;
   logic        issue;
   logic        halted;

   int n_tests = 0;
   int n_fail  = 0;

   localparam logic [31:0] W0 = 32'h0000_000A;
   localparam logic [31:0] W1 = 32'h0408_0001;
   localparam logic [31:0] W2 = 32'h0008_4800;
   localparam logic [31:0] W3 = 32'h0508_0001;

   inst_fetch_v2 dut (
      .CLK(CLK), .RST(RST),
      .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
      .run(run), .stall(stall),
      .redirect_en(redirect_en), .redirect_addr(redirect_addr),
      .INST(INST), .pc(pc), .inst_valid(inst_valid), .issue(issue), .halted(halted)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic expect_out(input string tag, input logic [31:0] e_inst, input logic [5:0] e_pc,
                             input logic e_vld, input logic e_iss, input logic e_halt);
      check({tag, ".inst"},   INST,       e_inst);
      check({tag, ".pc"},     32'(pc),    32'(e_pc));
      check({tag, ".vld"},    32'(inst_valid), 32'(e_vld));
      check({tag, ".issue"},  32'(issue), 32'(e_iss));
      check({tag, ".halted"}, 32'(halted), 32'(e_halt));
   endtask

   task automatic load(input logic [5:0] a, input logic [31:0] d);
      load_en = 1'b1; load_addr = a; load_data = d;
      tick();
      load_en = 1'b0;
   endtask

   logic [31:0] seq_inst [8];
   logic [5:0]  seq_pc   [8];

   initial begin
      RST = 1'b0; load_en = 1'b0; load_addr = '0; load_data = '0;
      run = 1'b0; stall = 1'b0; redirect_en = 1'b0; redirect_addr = '0;
      #2;
      expect_out("reset", 32'h0, 6'd0, 1'b0, 1'b0, 1'b0);
      @(negedge CLK);
      RST = 1'b1;
      tick();

      load(6'd0, W0); load(6'd1, W1); load(6'd2, W2); load(6'd3, W3);
      load(6'd63, 32'h0000_0001);
      expect_out("idle", 32'h0, 6'd0, 1'b0, 1'b0, 1'b0);

      // Straight-line run: each word held for two cycles.
      seq_inst = '{W0, W0, W1, W1, W2, W2, W3, W3};
      seq_pc   = '{6'd0, 6'd0, 6'd1, 6'd1, 6'd2, 6'd2, 6'd3, 6'd3};
      run = 1'b1;
      for (int i = 0; i < 8; i++) begin
         tick();
         expect_out($sformatf("seq%0d", i), seq_inst[i], seq_pc[i], 1'b1, (i % 2) == 0, 1'b0);
      end
      run = 1'b0;
      tick();
      expect_out("abort", 32'h0, 6'd0, 1'b0, 1'b0, 1'b0);

      // Stall for three cycles at pc=1 with an ignored redirect inside the stall.
      run = 1'b1;
      tick(); tick(); tick();
      expect_out("pc1_first", W1, 6'd1, 1'b1, 1'b1, 1'b0);
      stall = 1'b1; redirect_en = 1'b1; redirect_addr = 6'd3;
      for (int i = 0; i < 3; i++) begin
         tick();
         expect_out($sformatf("stall%0d", i), W1, 6'd1, 1'b1, 1'b0, 1'b0);
      end
      stall = 1'b0; redirect_en = 1'b0;
      tick();
      expect_out("stall_tail", W1, 6'd1, 1'b1, 1'b0, 1'b0);
      tick();
      expect_out("post_stall", W2, 6'd2, 1'b1, 1'b1, 1'b0);

      // Redirect at the boundary after pc=2, no bubble.
      tick();
      redirect_en = 1'b1; redirect_addr = 6'd0;
      tick();
      expect_out("redir0", W0, 6'd0, 1'b1, 1'b1, 1'b0);

      // Redirect outside the boundary cycle is ignored.
      redirect_addr = 6'd9;
      tick();
      expect_out("redir_mid", W0, 6'd0, 1'b1, 1'b0, 1'b0);
      redirect_addr = 6'd63;
      tick();
      expect_out("redir63", 32'h0000_0001, 6'd63, 1'b1, 1'b1, 1'b0);
      redirect_en = 1'b0;
      tick(); tick();
      expect_out("wrap", W0, 6'd0, 1'b1, 1'b1, 1'b0);

      // Sentinel at mem[2]; also a load attempted while run=1 must be dropped.
      run = 1'b0;
      tick();
      load(6'd2, 32'hFFFF_FFFF);
      run = 1'b1; load_en = 1'b1; load_addr = 6'd0; load_data = 32'hDEAD_BEEF;
      tick();
      load_en = 1'b0;
      expect_out("restart", W0, 6'd0, 1'b1, 1'b1, 1'b0);
      tick(); tick(); tick(); tick();
`ifdef IFETCH_HALT_EN
      expect_out("halt", 32'h0, 6'd2, 1'b0, 1'b0, 1'b1);
      tick();
      expect_out("halt_hold", 32'h0, 6'd2, 1'b0, 1'b0, 1'b1);
`else
      expect_out("sentinel_issue", 32'hFFFF_FFFF, 6'd2, 1'b1, 1'b1, 1'b0);
`endif
      run = 1'b0;
      tick();
      expect_out("halt_exit", 32'h0, 6'd0, 1'b0, 1'b0, 1'b0);

      // Restart proves mem[0] kept its value, then async reset mid-hold.
      run = 1'b1;
      tick();
      expect_out("mem0_kept", W0, 6'd0, 1'b1, 1'b1, 1'b0);
      tick();
      RST = 1'b0;
      #1;
      expect_out("async_rst", 32'h0, 6'd0, 1'b0, 1'b0, 1'b0);
      RST = 1'b1;
      tick();
      expect_out("post_rst", W0, 6'd0, 1'b1, 1'b1, 1'b0);
      tick(); tick();
      expect_out("post_rst_pc1", W1, 6'd1, 1'b1, 1'b1, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/inst_fetch_v2.md
# inst_fetch_v2

Instruction sequencer that drives the 32-bit `INST` input of the MIPS core from a small writable instruction store, replacing hand-fed instruction streams. A host loads the program word by word while idle, then asserts `run`. The block issues one instruction every `HOLD_CYCLES` clocks, advances a program counter, accepts branch redirects and stalls, and optionally halts on a sentinel word. It sits between the program loader and the core's `INST` port.

## Interface
- `DEPTH_LOG2`, 6, log2 of store depth (64 words); PC width
- `HOLD_CYCLES`, 2, clocks each instruction is held on `INST`; legal range 1..15
- `CLK` input 1, clock; all state updates on rising edge
- `RST` input 1, asynchronous, active-low reset
- `load_en` input 1, write `load_data` to `mem[load_addr]`
- `load_addr` input DEPTH_LOG2, load address
- `load_data` input 32, load word
- `run` input 1, level; 1 = execute, 0 = return to IDLE
- `stall` input 1, freeze hold counter, PC and `INST`
- `redirect_en` input 1, take `redirect_addr` as the next PC
- `redirect_addr` input DEPTH_LOG2, branch/jump target
- `INST` output 32, instruction presented to core
- `pc` output DEPTH_LOG2, address of the word on `INST`
- `inst_valid` output 1, `INST` holds a fetched word
- `issue` output 1, one-cycle pulse when a new word is placed on `INST`
- `halted` output 1, sentinel reached (HALT state)

## Operation
- States: IDLE, HOLD, HALT. `mem` is a register array with combinational read.
- IDLE:
  - `INST` = 0, `pc` = 0, `inst_valid` = 0, `halted` = 0.
  - `load_en` with `run`=0 writes `mem`. `load_en` is ignored in every other case, including IDLE with `run`=1.
  - `run`=1: `INST`<=`mem[0]`, `pc`<=0, `cnt`<=HOLD_CYCLES-1, `issue`=1, go to HOLD.
- HOLD:
  - `stall`=1: nothing changes. `redirect_en` is ignored.
  - `stall`=0 and `cnt`!=0: `cnt` decrements.
  - `stall`=0 and `cnt`==0: next address na = `redirect_en` ? `redirect_addr` : `pc`+1, modulo 2^DEPTH_LOG2 (wraps 63→0). Then `pc`<=na, `INST`<=`mem[na]`, `cnt`<=HOLD_CYCLES-1, `issue`=1.
  - `redirect_en` is sampled only at that boundary cycle. Redirect has priority over increment.
- HALT: `INST`=0, `inst_valid`=0, `halted`=1. `pc` holds the sentinel's address. The state persists until `run`=0.
- `run`=0 in any state: next edge goes to IDLE with all IDLE values. This overrides stall and redirect.
- `mem` contents are not cleared by `RST` or by `run`=0. Program reload is required only after power-up.

## Timing
- Reset (async assert, `RST`=0): state IDLE, `INST`=0, `pc`=0, `cnt`=0, `inst_valid`=0, `issue`=0, `halted`=0.
- Load: write takes effect at the edge; a word written at edge k is readable in the cycle after edge k.
- Start latency: `run` sampled high at edge k → `INST`=`mem[0]`, `issue`=1 in cycle after k.
- Issue period: exactly HOLD_CYCLES clocks per instruction with no stall. Each stalled cycle adds one clock.
- HOLD_CYCLES=1: a new word every cycle and `issue` stays high continuously.
- `issue` is high only in the first cycle a word is on `INST`. It is never high in IDLE or HALT.
- Redirect: `redirect_en` high in boundary cycle at edge k → `INST`=`mem[redirect_addr]` after k. There is no bubble.

## Configuration
- `IFETCH_HALT_EN` defined:
  - A fetched word of 32'hFFFF_FFFF (at start or at any boundary) is not issued.
  - The block enters HALT at that edge with `pc`=sentinel address and `issue`=0.
- `IFETCH_HALT_EN` undefined:
  - 32'hFFFF_FFFF is issued like any other word.
  - HALT is unreachable and `halted` is tied 0. The PC free-runs with wrap.

## Test plan
- Load: `mem[0..3]` = 0000000A, 04080001, 00084800, 05080001; `run`=1, HOLD_CYCLES=2 → `INST` shows each word for exactly 2 cycles, `pc` 0,1,2,3, `issue` pulses every 2nd cycle.
- Stall: assert `stall` for 3 cycles while `pc`=1 → word 04080001 is held for 5 cycles total, and `redirect_en` pulses inside the stall are ignored.
- Redirect: `redirect_en`=1, `redirect_addr`=0 at the boundary after `pc`=2 → next `pc`=0, `INST`=0000000A, with no extra cycle.
- Wrap: `mem[63]`=00000001, `mem[0]`=0000000A, redirect to 63 → after 2 cycles, `pc`=0 and `INST`=0000000A.
- Halt (`IFETCH_HALT_EN`): `mem[2]`=FFFFFFFF → after `pc`=1 completes, `halted`=1, `INST`=0, `inst_valid`=0, `pc`=2. Without the macro, FFFFFFFF is issued at `pc`=2.
- Reset/abort: drop `RST` mid-HOLD → all outputs 0 immediately and `mem` retained. Drop `run` mid-HOLD → IDLE next edge. Re-raise `run` → restarts at `mem[0]`. `load_en` with `run`=1 does not change `mem`.
